// File: rtl/dmem_responder.sv
// Data-memory responder: posted in-order store buffer in front of a single-ported word RAM,
// with combinational loads forwarded from the youngest matching buffer entry.
// Optional store coalescing is enabled by defining DMEM_SB_COALESCE_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned SB_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        dmem_write,
  input  logic                        dmem_read,
  input  logic [31:0]                 addr,
  input  logic [31:0]                 dmem_write_data,
  output logic [31:0]                 dmem_read_data,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        sb_empty,
  output logic                        sb_full,
  output logic                        sb_overflow
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(SB_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   ram     [DEPTH_WORDS];
  logic [AW-1:0] sb_widx [SB_DEPTH];
  logic [31:0]   sb_data [SB_DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [AW-1:0] widx;
  logic          drain;
  logic          enq;
  logic          drop;
  logic          coal_hit;
  logic [CW-1:0] count_nxt;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic          unused_addr;

  // Word accesses only; upper bits alias modulo the RAM size.
  assign widx        = addr[AW+1:2];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

  // The RAM port is free for the buffer whenever no load is using it.
  assign drain = ~dmem_read & (sb_count != '0);

`ifdef DMEM_SB_COALESCE_EN
  logic [PW-1:0] coal_idx;

  // A head entry that leaves this cycle cannot absorb the store.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int k = 0; k < int'(SB_DEPTH); k++) begin
      if ((CW'(k) < sb_count) && !(k == 0 && drain) &&
          (sb_widx[head + PW'(k)] == widx)) begin
        coal_hit = 1'b1;
        coal_idx = head + PW'(k);
      end
    end
  end
`else
  assign coal_hit = 1'b0;
`endif

  // A full buffer accepts a store only if the head drains in the same cycle.
  assign enq       = dmem_write & ~coal_hit & (~sb_full | drain);
  assign drop      = dmem_write & ~coal_hit & sb_full & ~drain;
  assign count_nxt = sb_count + CW'(enq) - CW'(drain);

  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      sb_count    <= '0;
      sb_empty    <= 1'b1;
      sb_full     <= 1'b0;
      sb_overflow <= 1'b0;
    end else begin
      if (enq) begin
        tail <= tail + PW'(1);
      end
      if (drain) begin
        head <= head + PW'(1);
      end
      sb_count <= count_nxt;
      sb_empty <= (count_nxt == '0);
      sb_full  <= (count_nxt == CW'(SB_DEPTH));
      if (drop) begin
        sb_overflow <= 1'b1;
      end
    end
  end

  // Entry payloads carry no reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (enq) begin
        sb_widx[tail] <= widx;
        sb_data[tail] <= dmem_write_data;
      end
`ifdef DMEM_SB_COALESCE_EN
      if (dmem_write && coal_hit) begin
        sb_data[coal_idx] <= dmem_write_data;
      end
`endif
    end
  end

  // RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (!reset && drain) begin
      ram[sb_widx[head]] <= sb_data[head];
    end
  end

  // Walk oldest to youngest so the last match is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < int'(SB_DEPTH); k++) begin
      if ((CW'(k) < sb_count) && (sb_widx[head + PW'(k)] == widx)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[head + PW'(k)];
      end
    end
  end

  assign dmem_read_data = fwd_hit ? fwd_data : ram[widx];

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios with a queue of expected load data.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_write;
  logic        dmem_read;
  logic [31:0] addr;
  logic [31:0] dmem_write_data;
  logic [31:0] dmem_read_data;
  logic [2:0]  sb_count;
  logic        sb_empty;
  logic        sb_full;
  logic        sb_overflow;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  dmem_responder #(.DEPTH_WORDS(64), .SB_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .dmem_write     (dmem_write),
    .dmem_read      (dmem_read),
    .addr           (addr),
    .dmem_write_data(dmem_write_data),
    .dmem_read_data (dmem_read_data),
    .sb_count       (sb_count),
    .sb_empty       (sb_empty),
    .sb_full        (sb_full),
    .sb_overflow    (sb_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    dmem_write      = w;
    dmem_read       = r;
    addr            = a;
    dmem_write_data = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (sb_count !== 3'd0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", sb_count);
    end
    checks++;
    if ({sb_empty, sb_full, sb_overflow} !== 3'b100) begin
      failures++; $display("FAIL reset_flags got=%b exp=100", {sb_empty, sb_full, sb_overflow});
    end
  endtask

  task automatic test_store_basic();
    drive(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, 32'h10, 32'h0);
    #1;
    checks++;
    if (dmem_read_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL fwd_basic got=%h exp=deadbeef", dmem_read_data);
    end
    checks++;
    if (sb_count !== 3'd1) begin
      failures++; $display("FAIL count_after_store got=%0d exp=1", sb_count);
    end
    tick();
    drive(1'b0, 1'b1, 32'h10, 32'h0);
    #1;
    checks++;
    if (sb_count !== 3'd0 || sb_empty !== 1'b1) begin
      failures++; $display("FAIL count_after_drain got=%0d empty=%b exp=0/1", sb_count, sb_empty);
    end
    checks++;
    if (dmem_read_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL ram_basic got=%h exp=deadbeef", dmem_read_data);
    end
    tick();
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'(i * 4), 32'(i + 1));
      tick();
    end
    drive(1'b0, 1'b1, 32'h0, 32'h0);
    #1;
    checks++;
    if (sb_count !== 3'd4 || sb_full !== 1'b1 || sb_overflow !== 1'b0) begin
      failures++; $display("FAIL fill got count=%0d full=%b ovf=%b exp=4/1/0", sb_count, sb_full, sb_overflow);
    end
    drive(1'b1, 1'b1, 32'h10, 32'h5);
    tick();
    drive(1'b0, 1'b1, 32'h10, 32'h0);
    #1;
    checks++;
    if (sb_count !== 3'd4 || sb_overflow !== 1'b1) begin
      failures++; $display("FAIL overflow got count=%0d ovf=%b exp=4/1", sb_count, sb_overflow);
    end
    checks++;
    if (dmem_read_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL dropped_store_visible got=%h exp=deadbeef", dmem_read_data);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4), 32'h0);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (dmem_read_data !== exp) begin
        failures++; $display("FAIL fwd_full[%0d] got=%h exp=%h", i, dmem_read_data, exp);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 3; i >= 0; i--) begin
      tick();
      checks++;
      if (sb_count !== 3'(i)) begin
        failures++; $display("FAIL drain_count got=%0d exp=%0d", sb_count, i);
      end
    end
    checks++;
    if (sb_empty !== 1'b1) begin
      failures++; $display("FAIL drain_empty got=%b exp=1", sb_empty);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 1));
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4), 32'h0);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (dmem_read_data !== exp) begin
        failures++; $display("FAIL ram_fill[%0d] got=%h exp=%h", i, dmem_read_data, exp);
      end
    end
    tick();
  endtask

  task automatic test_same_addr();
    int n;
    logic [2:0] exp_cnt;
`ifdef DMEM_SB_COALESCE_EN
    exp_cnt = 3'd1;
`else
    exp_cnt = 3'd2;
`endif
    drive(1'b1, 1'b1, 32'h20, 32'hA);
    tick();
    drive(1'b1, 1'b1, 32'h20, 32'hB);
    tick();
    drive(1'b0, 1'b1, 32'h20, 32'h0);
    #1;
    exp_q.push_back(32'hB);
    exp = exp_q.pop_front();
    checks++;
    if (dmem_read_data !== exp) begin
      failures++; $display("FAIL youngest_wins got=%h exp=%h", dmem_read_data, exp);
    end
    checks++;
    if (sb_count !== exp_cnt) begin
      failures++; $display("FAIL same_addr_count got=%0d exp=%0d", sb_count, exp_cnt);
    end
    checks++;
    if (sb_overflow !== 1'b1) begin
      failures++; $display("FAIL overflow_sticky got=%b exp=1", sb_overflow);
    end
    drive(1'b0, 1'b0, 32'h20, 32'h0);
    n = 0;
    while (sb_empty !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    checks++;
    if (sb_empty !== 1'b1) begin
      failures++; $display("FAIL same_addr_drain_timeout empty=%b exp=1", sb_empty);
    end
    drive(1'b0, 1'b1, 32'h20, 32'h0);
    #1;
    checks++;
    if (dmem_read_data !== 32'hB) begin
      failures++; $display("FAIL same_addr_ram got=%h exp=0000000b", dmem_read_data);
    end
    tick();
  endtask

  task automatic test_reset_discard();
    drive(1'b1, 1'b0, 32'h14, 32'h55);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 32'h14, 32'h77);
    tick();
    drive(1'b1, 1'b1, 32'h18, 32'h1);
    tick();
    drive(1'b1, 1'b1, 32'h1C, 32'h2);
    tick();
    drive(1'b0, 1'b1, 32'h14, 32'h0);
    #1;
    checks++;
    if (sb_count !== 3'd3 || dmem_read_data !== 32'h77) begin
      failures++; $display("FAIL pre_reset got count=%0d data=%h exp=3/77", sb_count, dmem_read_data);
    end
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h14, 32'h66);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'h14, 32'h0);
    #1;
    checks++;
    if (sb_count !== 3'd0 || {sb_empty, sb_full, sb_overflow} !== 3'b100) begin
      failures++; $display("FAIL post_reset got count=%0d flags=%b exp=0/100", sb_count, {sb_empty, sb_full, sb_overflow});
    end
    checks++;
    if (dmem_read_data !== 32'h55) begin
      failures++; $display("FAIL post_reset_data got=%h exp=00000055", dmem_read_data);
    end
    tick();
    #1;
    checks++;
    if (dmem_read_data !== 32'h55 || sb_count !== 3'd0) begin
      failures++; $display("FAIL reset_store_rejected got data=%h count=%0d exp=55/0", dmem_read_data, sb_count);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'(32'h40 + i * 4), 32'(32'h11 * (i + 1)));
      tick();
    end
    drive(1'b1, 1'b0, 32'h50, 32'h55);
    tick();
    drive(1'b0, 1'b1, 32'h50, 32'h0);
    #1;
    checks++;
    if (sb_count !== 3'd4 || sb_overflow !== 1'b0 || dmem_read_data !== 32'h55) begin
      failures++; $display("FAIL full_store_drain got count=%0d ovf=%b data=%h exp=4/0/55", sb_count, sb_overflow, dmem_read_data);
    end
    drive(1'b1, 1'b0, 32'h54, 32'h66);
    tick();
    drive(1'b0, 1'b1, 32'h40, 32'h0);
    #1;
    checks++;
    if (sb_count !== 3'd4 || dmem_read_data !== 32'h11) begin
      failures++; $display("FAIL enq_drain got count=%0d data=%h exp=4/11", sb_count, dmem_read_data);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    while (sb_empty !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (sb_empty !== 1'b1) begin
      failures++; $display("FAIL b2b_drain_timeout empty=%b exp=1", sb_empty);
    end
    for (int i = 1; i < 6; i++) exp_q.push_back(32'(32'h11 * (i + 1)));
    for (int i = 1; i < 6; i++) begin
      drive(1'b0, 1'b1, 32'(32'h40 + i * 4), 32'h0);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (dmem_read_data !== exp) begin
        failures++; $display("FAIL b2b_ram[%0d] got=%h exp=%h", i, dmem_read_data, exp);
      end
    end
    tick();
  endtask

  task automatic test_aliasing();
    drive(1'b1, 1'b0, 32'h100, 32'h99);
    tick();
    drive(1'b0, 1'b1, 32'h0, 32'h0);
    #1;
    checks++;
    if (dmem_read_data !== 32'h99 || sb_count !== 3'd1) begin
      failures++; $display("FAIL alias_fwd got data=%h count=%0d exp=99/1", dmem_read_data, sb_count);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h103, 32'h0);
    #1;
    checks++;
    if (dmem_read_data !== 32'h99 || sb_count !== 3'd0) begin
      failures++; $display("FAIL alias_ram got data=%h count=%0d exp=99/0", dmem_read_data, sb_count);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_basic();
    test_fill_overflow();
    test_same_addr();
    test_reset_discard();
    test_back_to_back();
    test_aliasing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's MEM-stage dmem port. It accepts stores and serves combinational loads from a single-ported word RAM.
- Stores are posted into a small in-order store buffer. The buffer drains to the RAM on cycles when the RAM port is not needed for a load.
- Loads forward from the youngest matching buffer entry, so the core always sees program-order data without stalling.

Parameters:
- DEPTH_WORDS, 64, RAM size in 32-bit words; must be a power of 2 (min 4).
- SB_DEPTH, 4, store-buffer entries; must be a power of 2 (min 2).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- dmem_write  input  1  store request this cycle.
- dmem_read  input  1  load request this cycle; the RAM port is busy serving the load.
- addr  input  32  byte address (core ALU result).
- dmem_write_data  input  32  store data.
- dmem_read_data  output  32  load data, combinational.
- sb_count  output  $clog2(SB_DEPTH)+1  number of valid buffer entries.
- sb_empty  output  1  sb_count == 0.
- sb_full  output  1  sb_count == SB_DEPTH.
- sb_overflow  output  1  sticky flag: a store was dropped.

Behaviour:
- Word index: widx = addr[$clog2(DEPTH_WORDS)+1:2].
  - addr[1:0] are ignored; all accesses are word accesses.
  - Upper address bits are ignored, so addresses alias modulo DEPTH_WORDS*4.
- Store buffer: circular FIFO of {widx, data} with head and tail pointers that wrap at SB_DEPTH.
- Enqueue: when dmem_write=1, the entry is written at the tail at the posedge.
- Drain:
  - drain = ~dmem_read & ~sb_empty.
  - On drain, the head entry is written to RAM[head.widx] at the posedge and the head advances.
- Simultaneous enqueue and drain: both happen; sb_count is unchanged.
- Full, store and no read: a drain happens the same cycle, so the store is accepted and sb_count stays SB_DEPTH.
- Full, store and read (drain blocked):
  - The store is dropped; sb_count stays SB_DEPTH.
  - sb_overflow sets at the posedge and holds until reset.
- Load data, combinational and valid the same cycle:
  - dmem_read_data = data of the youngest valid buffer entry whose widx matches; otherwise RAM[widx].
  - The store being enqueued in the current cycle is not visible until the next cycle.
  - dmem_read_data is driven regardless of dmem_read (the core ignores it when not loading).
- Read and write both high in one cycle: the load is served, the store is enqueued (subject to the full rule) and drain is suppressed.
- Reset (takes priority over all other activity):
  - head, tail and count become 0; sb_empty=1, sb_full=0, sb_overflow=0.
  - Pending entries are discarded.
  - RAM contents are not altered by reset.
  - A store presented in the reset cycle is not accepted.
  - After reset, dmem_read_data = RAM[widx].
- Latency: a store is visible to loads 1 cycle after issue via forwarding. It reaches RAM at the earliest on the posedge that ends its issue cycle+1.

Optional Feature:
- Macro: DMEM_SB_COALESCE_EN.
- Defined: a store whose widx matches an existing valid entry overwrites that entry's data in place instead of enqueueing.
  - sb_count does not change.
  - The store is accepted even when the buffer is full.
  - If the match is the head entry and it drains in the same cycle, the store enqueues normally instead.
- Undefined: every store enqueues; duplicate widx entries are allowed and the youngest wins on forwarding.

Test Plan:
- Reset, then store 0xDEADBEEF @0x10 with dmem_read=0 -> next cycle load @0x10 returns 0xDEADBEEF and sb_count=1. The cycle after that, sb_count=0 and RAM[4]=0xDEADBEEF.
- Four stores 0x1,0x2,0x3,0x4 to @0x0,0x4,0x8,0xC, each with dmem_read=1 -> sb_count=4, sb_full=1. A fifth store with dmem_read=1 -> sb_overflow=1, sb_count=4.
- Fill as above, then 4 idle cycles -> sb_count 3,2,1,0 and sb_empty=1. Loads then return 0x1..0x4 from RAM.
- Store 0xA then 0xB to @0x20, both with dmem_read=1 -> load @0x20 returns 0xB. After drain, RAM[8]=0xB.
  - Without the macro, sb_count=2 before drain; with DMEM_SB_COALESCE_EN, sb_count=1.
- RAM[5]=0x55. Store 0x77 @0x14 and hold drain blocked until sb_count=3, then assert reset -> sb_count=0, sb_overflow=0, load @0x14 returns 0x55.
- DEPTH_WORDS=64: store 0x99 @0x100 -> load @0x0 returns 0x99 (aliasing). Load @0x103 returns the same word.
